// File: rtl/tick_scheduler_pkg.sv
// Shared timing definitions for the snake game: scheduler states, default
// divider constants and the speed-level clamp.
package snake_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sched_state_e;

  localparam int DEF_REFRESH_DIV   = 100000;
  localparam int DEF_BLINK_DIV     = 25000000;
  localparam int DEF_GAME_BASE_DIV = 50000000;
  localparam int DEF_GAME_STEP_DIV = 5000000;
  localparam int DEF_LEVELS        = 8;

  function automatic logic [2:0] clamp_level(input logic [2:0] lvl, input int levels);
    if (int'(lvl) > levels - 1) return 3'(levels - 1);
    return lvl;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between the game logic and tick_scheduler.
// The boost input exists only when TICK_SCHED_BOOST_EN is defined.
interface tick_scheduler_if;
  logic       start;
  logic       pause_tgl;
  logic       stop;
  logic [2:0] level;
`ifdef TICK_SCHED_BOOST_EN
  logic       boost;
`endif
  logic       refresh_en;
  logic       blink_en;
  logic       blink_phase;
  logic       step_en;
  logic       running;
  logic       paused;
  logic [2:0] level_cur;

`ifdef TICK_SCHED_BOOST_EN
  modport master (output start, pause_tgl, stop, level, boost,
                  input  refresh_en, blink_en, blink_phase, step_en, running, paused, level_cur);
  modport slave  (input  start, pause_tgl, stop, level, boost,
                  output refresh_en, blink_en, blink_phase, step_en, running, paused, level_cur);
`else
  modport master (output start, pause_tgl, stop, level,
                  input  refresh_en, blink_en, blink_phase, step_en, running, paused, level_cur);
  modport slave  (input  start, pause_tgl, stop, level,
                  output refresh_en, blink_en, blink_phase, step_en, running, paused, level_cur);
`endif
endinterface

// File: rtl/tick_scheduler_strobe_div.sv
// Enable-gated modulo counter producing a registered one-cycle strobe the
// cycle after it wraps; wrap is exposed so the owner can act on the boundary.
module strobe_div #(
  parameter int DIV = 4,
  parameter int PW  = $clog2(DIV + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] period,
  output logic          strobe,
  output logic          wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  always_comb begin
    wrap     = en && !clr && (PW'(cnt_q) == (period - PW'(1)));
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d    = '0;
      strobe_d = 1'b1;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/tick_scheduler.sv
// Timebase strobes and game-step sequencer (IDLE/RUN/PAUSE) for the snake game.
// Define TICK_SCHED_BOOST_EN to add the boost input that halves the next period.
module tick_scheduler
  import snake_timing_pkg::*;
#(
  parameter int REFRESH_DIV   = DEF_REFRESH_DIV,
  parameter int BLINK_DIV     = DEF_BLINK_DIV,
  parameter int GAME_BASE_DIV = DEF_GAME_BASE_DIV,
  parameter int GAME_STEP_DIV = DEF_GAME_STEP_DIV,
  parameter int LEVELS        = DEF_LEVELS
) (
  input logic            clk,
  input logic            rst_n,
  tick_scheduler_if.slave bus
);

  localparam int RPW = $clog2(REFRESH_DIV + 1);
  localparam int BPW = $clog2(BLINK_DIV + 1);
  localparam int GPW = $clog2(GAME_BASE_DIV + 1);

  sched_state_e state_q, state_d;
  logic [2:0]   level_cur_q, level_cur_d;
  logic         blink_phase_q, blink_phase_d;
  logic         start_acc, game_clr, game_wrap;
  logic         refresh_wrap, blink_wrap;
  logic         refresh_strobe, blink_strobe, step_strobe;
  logic [GPW-1:0] base_period, game_period;

  assign start_acc = bus.start && !bus.stop && (state_q == ST_IDLE);
  assign game_clr  = bus.stop || start_acc;

  strobe_div #(.DIV(REFRESH_DIV), .PW(RPW)) u_refresh (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0),
    .period(RPW'(REFRESH_DIV)), .strobe(refresh_strobe), .wrap(refresh_wrap)
  );

  strobe_div #(.DIV(BLINK_DIV), .PW(BPW)) u_blink (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0),
    .period(BPW'(BLINK_DIV)), .strobe(blink_strobe), .wrap(blink_wrap)
  );

  strobe_div #(.DIV(GAME_BASE_DIV), .PW(GPW)) u_game (
    .clk(clk), .rst_n(rst_n), .en(state_q == ST_RUN), .clr(game_clr),
    .period(game_period), .strobe(step_strobe), .wrap(game_wrap)
  );

  assign base_period = GPW'(GAME_BASE_DIV) - GPW'(level_cur_q) * GPW'(GAME_STEP_DIV);

`ifdef TICK_SCHED_BOOST_EN
  logic           boost_q, boost_d;
  logic [GPW-1:0] half_period;

  // Boost is latched at the period boundary so a running period keeps its length.
  always_comb begin
    boost_d = boost_q;
    if (start_acc)      boost_d = 1'b0;
    else if (game_wrap) boost_d = bus.boost;
    half_period = base_period >> 1;
    if (half_period == '0) half_period = GPW'(1);
    game_period = boost_q ? half_period : base_period;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) boost_q <= 1'b0;
    else        boost_q <= boost_d;
  end
`else
  assign game_period = base_period;
`endif

  // stop wins over everything; level_cur only changes at start or a step boundary.
  always_comb begin
    state_d       = state_q;
    level_cur_d   = level_cur_q;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d     = ST_RUN;
            level_cur_d = clamp_level(bus.level, LEVELS);
          end
        end
        ST_RUN: begin
          if (game_wrap) level_cur_d = clamp_level(bus.level, LEVELS);
          if (bus.pause_tgl) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (bus.pause_tgl) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      level_cur_q   <= 3'd0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_cur_q   <= level_cur_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign bus.refresh_en  = refresh_strobe;
  assign bus.blink_en    = blink_strobe;
  assign bus.blink_phase = blink_phase_q;
  assign bus.step_en     = step_strobe;
  assign bus.running     = (state_q == ST_RUN);
  assign bus.paused      = (state_q == ST_PAUSE);
  assign bus.level_cur   = level_cur_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios plus randomized
// control pulses, all checked every cycle against a behavioural model.
module tb_tick_scheduler;

  localparam int RDIV  = 4;
  localparam int BDIV  = 10;
  localparam int BASE  = 20;
  localparam int STEP  = 2;
  localparam int LVLS  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tick_scheduler_if bus ();
  tick_scheduler_if bus4 ();

  tick_scheduler #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV), .GAME_BASE_DIV(BASE),
                   .GAME_STEP_DIV(STEP), .LEVELS(LVLS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  tick_scheduler #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV), .GAME_BASE_DIV(BASE),
                   .GAME_STEP_DIV(STEP), .LEVELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc;
  int   m_state;
  int   m_used;
  int   m_period;
  int   m_level;
  bit   m_boost;
  bit   exp_step;

  function automatic int periodFor(input int lvl, input bit b);
    int p;
    p = BASE - lvl * STEP;
    if (b) begin
      p = p / 2;
      if (p < 1) p = 1;
    end
    return p;
  endfunction

  function automatic int clampLvl(input logic [2:0] l, input int levels);
    return (int'(l) > levels - 1) ? levels - 1 : int'(l);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    cyc      = 0;
    m_state  = 0;
    m_used   = 0;
    m_level  = 0;
    m_boost  = 1'b0;
    m_period = BASE;
    exp_step = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic modelEdge();
    bit b;
`ifdef TICK_SCHED_BOOST_EN
    b = bus.boost;
`else
    b = 1'b0;
`endif
    exp_step = 1'b0;
    if (bus.stop) begin
      m_state = 0;
      m_used  = 0;
    end else if (m_state == 0) begin
      if (bus.start) begin
        m_state  = 1;
        m_used   = 0;
        m_level  = clampLvl(bus.level, LVLS);
        m_boost  = 1'b0;
        m_period = periodFor(m_level, m_boost);
      end
    end else if (m_state == 1) begin
      m_used++;
      if (m_used == m_period) begin
        exp_step = 1'b1;
        m_used   = 0;
        m_level  = clampLvl(bus.level, LVLS);
        m_boost  = b;
        m_period = periodFor(m_level, m_boost);
      end
      if (bus.pause_tgl) m_state = 2;
    end else if (bus.pause_tgl) begin
      m_state = 1;
    end
  endtask

  task automatic checkOutput();
    check("refresh_en",  32'(bus.refresh_en),  32'(cyc % RDIV == 0));
    check("blink_en",    32'(bus.blink_en),    32'(cyc % BDIV == 0));
    check("blink_phase", 32'(bus.blink_phase), 32'((cyc / BDIV) % 2));
    check("step_en",     32'(bus.step_en),     32'(exp_step));
    check("running",     32'(bus.running),     32'(m_state == 1));
    check("paused",      32'(bus.paused),      32'(m_state == 2));
    check("level_cur",   32'(bus.level_cur),   32'(m_level));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    modelEdge();
    checkOutput();
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit st, input logic [2:0] l);
    bus.start     = s;
    bus.pause_tgl = p;
    bus.stop      = st;
    bus.level     = l;
  endtask

  task automatic pulse(input bit s, input bit p, input bit st);
    applyStimulus(s, p, st, bus.level);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, bus.level);
  endtask

  task automatic waitStep(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.step_en && n < maxc);
    if (!bus.step_en) check("step_timeout", 32'(bus.step_en), 32'd1);
  endtask

  initial begin
    int n, nref, nblk, ntog, nstep, nfirst, guard;
    logic prev_phase;

    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
`ifdef TICK_SCHED_BOOST_EN
    bus.boost = 1'b0;
`endif
    bus4.start = 1'b0; bus4.pause_tgl = 1'b0; bus4.stop = 1'b0; bus4.level = 3'd0;
`ifdef TICK_SCHED_BOOST_EN
    bus4.boost = 1'b0;
`endif
    resetModel();

    #2;
    check("reset_outputs", {25'd0, bus.refresh_en, bus.blink_en, bus.blink_phase,
                            bus.step_en, bus.running, bus.paused, bus.level_cur != 3'd0}, 32'd0);
    #1 rst_n = 1'b1;

    $display("[TB] free-running strobes while idle");
    nref = 0; nblk = 0; ntog = 0; nstep = 0; prev_phase = bus.blink_phase;
    for (int i = 0; i < 40; i++) begin
      tick();
      nref  += int'(bus.refresh_en);
      nblk  += int'(bus.blink_en);
      nstep += int'(bus.step_en);
      if (bus.blink_phase !== prev_phase) ntog++;
      prev_phase = bus.blink_phase;
    end
    check("idle_refresh_count", 32'(nref), 32'd10);
    check("idle_blink_count",   32'(nblk), 32'd4);
    check("idle_phase_toggles", 32'(ntog), 32'd4);
    check("idle_step_count",    32'(nstep), 32'd0);

    $display("[TB] level 0 stepping");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    pulse(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitStep(40, n);
      check("lvl0_period", 32'(n), 32'(BASE));
    end
    pulse(1'b0, 1'b0, 1'b1);

    $display("[TB] level change applies at next period");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd7);
    pulse(1'b1, 1'b0, 1'b0);
    check("lvl7_level_cur", 32'(bus.level_cur), 32'd7);
    for (int k = 0; k < 3; k++) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd2);
    waitStep(40, n);
    check("lvl7_first_period", 32'(n + 3), 32'd6);
    check("lvl_resampled",     32'(bus.level_cur), 32'd2);
    waitStep(40, n);
    check("lvl2_period", 32'(n), 32'd16);
    pulse(1'b0, 1'b0, 1'b1);

    $display("[TB] clamp with LEVELS=4");
    bus4.level = 3'b111;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    check("clamp_level_cur", 32'(bus4.level_cur), 32'd3);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus4.step_en && n < 40);
    check("clamp_period", 32'(n), 32'd14);
    bus4.stop = 1'b1;
    tick();
    bus4.stop = 1'b0;

    $display("[TB] pause and resume");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    pulse(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    pulse(1'b0, 1'b1, 1'b0);
    nstep = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      nstep += int'(bus.step_en);
    end
    check("paused_steps", 32'(nstep), 32'd0);
    check("paused_flag",  32'(bus.paused), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    waitStep(40, n);
    check("resume_remaining", 32'(n), 32'd12);

    $display("[TB] stop and pause at the wrap");
    guard = 0;
    while (!(m_state == 1 && m_used == m_period - 1) && guard < 40) begin
      tick();
      guard++;
    end
    check("wrap_reached", 32'(guard < 40), 32'd1);
    pulse(1'b0, 1'b1, 1'b1);
    check("stop_wrap_step",    32'(bus.step_en), 32'd0);
    check("stop_wrap_running", 32'(bus.running), 32'd0);
    check("stop_wrap_paused",  32'(bus.paused), 32'd0);

    $display("[TB] async reset mid-run");
    pulse(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {25'd0, bus.refresh_en, bus.blink_en, bus.blink_phase,
                                  bus.step_en, bus.running, bus.paused, bus.level_cur != 3'd0}, 32'd0);
    resetModel();
    #1 rst_n = 1'b1;

`ifdef TICK_SCHED_BOOST_EN
    $display("[TB] boost halves the next period");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    bus.boost = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    waitStep(40, n);
    check("boost_first_period", 32'(n), 32'(BASE));
    waitStep(40, n);
    check("boost_half_period", 32'(n), 32'(BASE / 2));
    bus.boost = 1'b0;
    waitStep(40, n);
    check("boost_sampled_low", 32'(n), 32'(BASE / 2));
    waitStep(40, n);
    check("boost_released", 32'(n), 32'(BASE));
    pulse(1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] randomized control traffic");
    nfirst = 0;
    for (int k = 0; k < 800; k++) begin
      applyStimulus($urandom_range(15) == 0, $urandom_range(15) == 0,
                    $urandom_range(59) == 0,
                    ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : bus.level);
`ifdef TICK_SCHED_BOOST_EN
      if ($urandom_range(9) == 0) bus.boost = 1'($urandom_range(1));
`endif
      tick();
      nfirst += int'(bus.step_en);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, bus.level);
    $display("[TB] random phase saw %0d steps", nfirst);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
